// File: rtl/minus1_sched.sv
// Shared 1-of-4 hop-count decrementer: round-robin arbitrates NREQ header ports and
// decrements the granted offset one digit per cycle, returning data plus zero/error flags.
module minus1_sched #(
    parameter int NREQ   = 4,
    parameter int DIGITS = 2,
    parameter int IDW    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_vld,
    input  logic [NREQ*4*DIGITS-1:0]   req_data,
    output logic [NREQ-1:0]            req_rdy,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [4*DIGITS-1:0]        rsp_data,
    output logic [IDW-1:0]             rsp_id,
    output logic                       rsp_zero,
    output logic                       rsp_err
);

    localparam int W   = 4 * DIGITS;
    localparam int IXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     work_q, work_d;
    logic [IXW-1:0]   idx_q, idx_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;

    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic [W-1:0]     cap_data;
    logic             cap_zero;
    logic             cap_err;
    int               cand;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    // Value 0 wraps to 3 (borrow); any other one-hot value moves down one place.
    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'b0001) ? 4'b1000 : (d >> 1);
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_any && req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) cap_data = req_data[i*W +: W];
        end
        cap_zero = 1'b1;
        cap_err  = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (cap_data[j*4 +: 4] != 4'b0001) cap_zero = 1'b0;
            if (!digit_ok(cap_data[j*4 +: 4])) cap_err = 1'b1;
        end
    end

    // The accept strobe is combinational so the handshake completes in the grant cycle.
    always_comb begin
        req_rdy = '0;
        if (rst_n && (state_q == S_IDLE) && gnt_any) begin
            for (int i = 0; i < NREQ; i++) begin
                req_rdy[i] = (IDW'(i) == gnt_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        work_d  = work_q;
        idx_d   = idx_q;
        id_d    = id_q;
        zero_d  = zero_q;
        err_d   = err_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    work_d  = cap_data;
                    id_d    = gnt_idx;
                    zero_d  = cap_zero;
                    err_d   = cap_err;
                    ptr_d   = gnt_idx;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (err_q || zero_q) begin
                    state_d = S_RESP;
                    vld_d   = 1'b1;
                end else begin
                    for (int j = 0; j < DIGITS; j++) begin
                        if (j == int'(idx_q)) begin
                            work_d[j*4 +: 4] = digit_dec(work_q[j*4 +: 4]);
                            if (work_q[j*4 +: 4] == 4'b0001) begin
                                idx_d = idx_q + IXW'(1);
                            end else begin
                                state_d = S_RESP;
                                vld_d   = 1'b1;
                            end
                        end
                    end
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            work_q  <= '0;
            idx_q   <= '0;
            id_q    <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign rsp_vld  = vld_q;
    assign rsp_data = work_q;
    assign rsp_id   = id_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_minus1_sched.sv
// Bench for minus1_sched (NREQ=4, DIGITS=2): directed vector table, arbitration,
// backpressure and reset sequences, plus random traffic against a value-level model.
module tb_minus1_sched;

    localparam int NREQ = 4;
    localparam int DIGITS = 2;
    localparam int IDW = 2;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_vld;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] req_rdy;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [W-1:0]    rsp_data;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_zero;
    logic            rsp_err;

    int total = 0;
    int bad = 0;
    int model_ptr = NREQ - 1;

    minus1_sched #(.NREQ(NREQ), .DIGITS(DIGITS), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h required=0x%0h", name, got, exp);
        end
    endtask

    function automatic int dval(input logic [3:0] d);
        case (d)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Value-level reference: decode to an integer, subtract one, re-encode.
    function automatic void model(input logic [7:0] din, output logic [7:0] dout,
                                  output bit z, output bit e, output int lat);
        int v = 0;
        int tz = 0;
        bit lead = 1;
        e = 0;
        for (int j = 0; j < DIGITS; j++) begin
            if (dval(din[j*4 +: 4]) < 0) e = 1;
            else v += dval(din[j*4 +: 4]) * (1 << (2 * j));
        end
        z = !e && (v == 0);
        dout = din;
        lat = 2;
        if (e || z) return;
        for (int j = 0; j < DIGITS; j++) begin
            if (lead && dval(din[j*4 +: 4]) == 0) tz++;
            else lead = 0;
        end
        lat = tz + 2;
        v = v - 1;
        for (int j = 0; j < DIGITS; j++) begin
            dout[j*4 +: 4] = 4'b0001 << (v % 4);
            v = v / 4;
        end
    endfunction

    function automatic logic [7:0] partial(input logic [7:0] din, input int m);
        logic [7:0] r = din;
        for (int j = 0; j < m - 1 && j < DIGITS; j++) r[j*4 +: 4] = 4'b1000;
        return r;
    endfunction

    function automatic int exp_grant(input logic [3:0] mask, input int ptr);
        for (int off = 1; off <= NREQ; off++) begin
            if (mask[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Entered just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic run_txn(input logic [3:0] mask, input logic [31:0] pdata, input int hold,
                           output logic [7:0] gd, output bit gz, output bit ge,
                           output int glat, output int gid);
        logic [7:0] din, ed;
        logic [3:0] oh;
        bit ez, ee;
        int elat, g;
        g = exp_grant(mask, model_ptr);
        oh = 4'b0001 << g;
        req_vld = mask;
        req_data = pdata;
        rsp_rdy = 1'b0;
        @(negedge clk);
        check("grant", req_rdy, oh);
        @(posedge clk); #1;
        req_vld = '0;
        model_ptr = g;
        din = pdata[g*8 +: 8];
        model(din, ed, ez, ee, elat);
        glat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_vld === 1'b1) begin
                glat = k;
                break;
            end
            if (k < elat) check("calc_data", rsp_data, partial(din, k));
            @(posedge clk); #1;
        end
        gd = rsp_data;
        gz = rsp_zero;
        ge = rsp_err;
        gid = int'(rsp_id);
        check("rsp_id", rsp_id, g);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_vld = mask;
            @(negedge clk);
            check("hold_vld", rsp_vld, 1);
            check("hold_data", rsp_data, gd);
            check("hold_id", rsp_id, gid);
            check("hold_flags", {rsp_zero, rsp_err}, {gz, ge});
            check("no_accept_busy", req_rdy, 0);
        end
        req_vld = '0;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        check("vld_drop", rsp_vld, 0);
        check("data_kept", rsp_data, gd);
        check("id_kept", rsp_id, gid);
    endtask

    typedef struct {
        int         port;
        logic [7:0] din;
        logic [7:0] dout;
        bit         z;
        bit         e;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] gd, ed, din;
        logic [31:0] pdata;
        logic [3:0] mask, prev, oh;
        bit gz, ge, ez, ee;
        int glat, gid, elat, g, got_n;
        int exp_seq[5];

        tbl[0]  = '{0, 8'h24, 8'h22, 0, 0, 2};
        tbl[1]  = '{0, 8'h21, 8'h18, 0, 0, 3};
        tbl[2]  = '{1, 8'h11, 8'h11, 1, 0, 2};
        tbl[3]  = '{2, 8'h23, 8'h23, 0, 1, 2};
        tbl[4]  = '{3, 8'h01, 8'h01, 0, 1, 2};
        tbl[5]  = '{1, 8'h81, 8'h48, 0, 0, 3};
        tbl[6]  = '{2, 8'h88, 8'h84, 0, 0, 2};
        tbl[7]  = '{3, 8'h12, 8'h11, 0, 0, 2};
        tbl[8]  = '{0, 8'h00, 8'h00, 0, 1, 2};
        tbl[9]  = '{1, 8'h42, 8'h41, 0, 0, 2};
        tbl[10] = '{2, 8'h31, 8'h31, 0, 1, 2};
        tbl[11] = '{3, 8'h18, 8'h14, 0, 0, 2};
        exp_seq = '{0, 1, 2, 3, 0};

        rst_n = 1'b1;
        req_vld = 4'hF;
        req_data = 32'h24242424;
        rsp_rdy = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_vld", rsp_vld, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        check("rst_flags", {rsp_zero, rsp_err}, 0);
        check("rst_rdy", req_rdy, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All ports request continuously with the consumer always ready.
        rsp_rdy = 1'b1;
        got_n = 0;
        prev = '0;
        for (int c = 0; c < 40 && got_n < 5; c++) begin
            @(negedge clk);
            check("rdy_onehot", $countones(req_rdy) <= 1, 1);
            if (req_rdy != 0) begin
                check("rdy_pulse", prev, 0);
                oh = 4'b0001 << exp_seq[got_n];
                check("arb_order", req_rdy, oh);
                model_ptr = exp_seq[got_n];
                got_n++;
            end
            prev = req_rdy;
            @(posedge clk); #1;
        end
        check("arb_count", got_n, 5);
        req_vld = '0;
        repeat (6) @(posedge clk);
        #1 rsp_rdy = 1'b0;
        @(negedge clk);
        check("arb_drain", rsp_vld, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            pdata = $urandom();
            pdata[tbl[i].port*8 +: 8] = tbl[i].din;
            mask = 4'b0001 << tbl[i].port;
            run_txn(mask, pdata, 0, gd, gz, ge, glat, gid);
            check("tbl_data", gd, tbl[i].dout);
            check("tbl_zero", gz, tbl[i].z);
            check("tbl_err", ge, tbl[i].e);
            check("tbl_lat", glat, tbl[i].lat);
        end

        // Five cycles of backpressure, then an accept in the cycle right after the handshake.
        run_txn(4'b0010, 32'h00002400, 5, gd, gz, ge, glat, gid);
        check("bp_data", gd, 8'h22);
        run_txn(4'b0100, 32'h00210000, 0, gd, gz, ge, glat, gid);
        check("bp_next_data", gd, 8'h18);
        check("bp_next_lat", glat, 3);

        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            for (int p = 0; p < NREQ; p++) begin
                for (int j = 0; j < DIGITS; j++) begin
                    if ($urandom_range(0, 7) != 0) pdata[p*8 + j*4 +: 4] = 4'b0001 << $urandom_range(0, 3);
                    else pdata[p*8 + j*4 +: 4] = 4'($urandom());
                end
            end
            g = exp_grant(mask, model_ptr);
            din = pdata[g*8 +: 8];
            model(din, ed, ez, ee, elat);
            run_txn(mask, pdata, $urandom_range(0, 3), gd, gz, ge, glat, gid);
            check("rnd_data", gd, ed);
            check("rnd_flags", {gz, ge}, {ez, ee});
            check("rnd_lat", glat, elat);
        end

        // Reset while borrowing through digit 0 of 0x41.
        req_vld = 4'b0100;
        req_data = 32'h00410000;
        @(negedge clk);
        check("rc_grant", req_rdy, 4'b0100);
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        check("rc_calc1", rsp_data, 8'h41);
        @(posedge clk); #1;
        @(negedge clk);
        check("rc_borrow", rsp_data, 8'h48);
        rst_n = 1'b0;
        req_vld = 4'hF;
        #1;
        check("rc_vld", rsp_vld, 0);
        check("rc_data", rsp_data, 0);
        check("rc_id", rsp_id, 0);
        check("rc_flags", {rsp_zero, rsp_err}, 0);
        check("rc_rdy", req_rdy, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_vld = '0;
        model_ptr = NREQ - 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rc_no_ghost", rsp_vld, 0);
            @(posedge clk); #1;
        end
        run_txn(4'hF, 32'h24242424, 0, gd, gz, ge, glat, gid);
        check("rc_first_port", gid, 0);
        check("rc_after_data", gd, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
